// File: rtl/lsu_pkg.sv
// ============================================================================
// Module      : lsu_pkg
// Description : Shared encodings, FSM state constants and the access
//               legality check for the lsu_mem_port load/store initiator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package lsu_pkg;

    // One-hot access sizes presented to data_ram
    localparam logic [2:0] MODE_B = 3'b001;
    localparam logic [2:0] MODE_H = 3'b010;
    localparam logic [2:0] MODE_W = 3'b100;

    // FSM state encoding
    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_ACCESS = 3'd1;
    localparam state_t ST_WAIT   = 3'd2;
    localparam state_t ST_ERR    = 3'd3;
    localparam state_t ST_RESP   = 3'd4;

    // True when the request must not reach memory: non-one-hot size or an
    // address not aligned to the access size.
    function automatic logic lsu_misaligned(input logic [2:0] mode,
                                            input logic [1:0] addr_lo);
        logic bad;
        bad = 1'b1;
        case (mode)
            MODE_B:  bad = 1'b0;
            MODE_H:  bad = addr_lo[0];
            MODE_W:  bad = |addr_lo;
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_resp_buf.sv
// ============================================================================
// Module      : lsu_resp_buf
// Description : Single-entry response holding register with valid/ready.
//               Contents stay stable until the consumer accepts them.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_resp_buf #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] load_rdata,
    input  logic              load_err,
    input  logic              resp_ready,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err
);

    logic              r_valid;
    logic [DATA_W-1:0] r_rdata;
    logic              r_err;

    // Capture a finished transaction; drop valid once the consumer takes it
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else if (load) begin
            r_valid <= 1'b1;
            r_rdata <= load_rdata;
            r_err   <= load_err;
        end else if (r_valid && resp_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign resp_valid = r_valid;
    assign resp_rdata = r_rdata;
    assign resp_err   = r_err;

endmodule

`default_nettype wire

// File: rtl/lsu_mem_port.sv
// ============================================================================
// Module      : lsu_mem_port
// Description : MEM-stage load/store initiator towards data_ram. Accepts one
//               request, flags misaligned/illegal accesses without touching
//               memory, holds the SRAM interface for READ_LATENCY cycles on
//               loads and returns a buffered response.
//               Optional macro LSU_PERF_CNT_EN adds load/store/error
//               transaction counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_mem_port
    import lsu_pkg::*;
#(
    parameter int READ_LATENCY = 1,
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [2:0]        req_mode,
    input  logic              req_us,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
`ifdef LSU_PERF_CNT_EN
    output logic [31:0]       perf_load_cnt,
    output logic [31:0]       perf_store_cnt,
    output logic [31:0]       perf_err_cnt,
`endif
    output logic [ADDR_W-1:0] data_sram_addr,
    output logic [DATA_W-1:0] data_sram_wdata,
    output logic              data_sram_en,
    output logic              data_sram_we,
    output logic [2:0]        data_sram_mode,
    output logic              data_sram_us,
    input  logic [DATA_W-1:0] data_sram_rdata
);

    // Counter wide enough for the full legal latency range 0..7
    localparam int CNT_W = 3;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_we;
    logic              r_us;
    logic [2:0]        r_mode;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [CNT_W-1:0]  r_cnt;

    logic              w_accept;
    logic              w_req_err;
    logic              w_rd_done;
    logic              w_resp_load;
    logic              w_resp_err;
    logic [DATA_W-1:0] w_resp_rdata;

    assign req_ready = (r_state == ST_IDLE);
    assign w_accept  = req_valid && req_ready;
    assign w_req_err = lsu_misaligned(req_mode, req_addr[1:0]);

    // Cycle in which a load samples data_sram_rdata
    generate
        if (READ_LATENCY == 0) begin : g_lat_zero
            assign w_rd_done = (r_state == ST_ACCESS) && !r_we;
        end else begin : g_lat_wait
            assign w_rd_done = (r_state == ST_WAIT) && (r_cnt == CNT_W'(1));
        end
    endgenerate

    // A transaction enters RESP from ERR, from a store's ACCESS cycle, or
    // from the load's sampling cycle
    assign w_resp_load  = (r_state == ST_ERR) ||
                          ((r_state == ST_ACCESS) && r_we) ||
                          w_rd_done;
    assign w_resp_err   = (r_state == ST_ERR);
    assign w_resp_rdata = w_rd_done ? data_sram_rdata : '0;

    // Next-state selection
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = w_req_err ? ST_ERR : ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                w_state_nxt = (r_we || w_rd_done) ? ST_RESP : ST_WAIT;
            end
            ST_WAIT: begin
                if (w_rd_done) begin
                    w_state_nxt = ST_RESP;
                end
            end
            ST_ERR: begin
                w_state_nxt = ST_RESP;
            end
            ST_RESP: begin
                if (resp_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Request fields are held from accept until the next accept, so the
    // SRAM address/data stay stable throughout ACCESS/WAIT and afterwards
    always_ff @(posedge clk) begin
        if (rst) begin
            r_we    <= 1'b0;
            r_us    <= 1'b0;
            r_mode  <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (w_accept) begin
            r_we    <= req_we;
            r_us    <= req_us;
            r_mode  <= req_mode;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
        end
    end

    // Read latency counter: loaded in ACCESS, counts down through WAIT
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (r_state == ST_ACCESS) begin
            r_cnt <= CNT_W'(READ_LATENCY);
        end else if (r_state == ST_WAIT) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign data_sram_en    = (r_state == ST_ACCESS) || (r_state == ST_WAIT);
    assign data_sram_we    = (r_state == ST_ACCESS) && r_we;
    assign data_sram_addr  = r_addr;
    assign data_sram_wdata = r_wdata;
    assign data_sram_mode  = r_mode;
    assign data_sram_us    = r_us;

    lsu_resp_buf #(
        .DATA_W (DATA_W)
    ) u_resp_buf (
        .clk        (clk),
        .rst        (rst),
        .load       (w_resp_load),
        .load_rdata (w_resp_rdata),
        .load_err   (w_resp_err),
        .resp_ready (resp_ready),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

`ifdef LSU_PERF_CNT_EN
    // Count each transaction once, as it enters RESP
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_load_cnt  <= '0;
            perf_store_cnt <= '0;
            perf_err_cnt   <= '0;
        end else if (w_resp_load) begin
            if (w_resp_err) begin
                perf_err_cnt <= perf_err_cnt + 32'd1;
            end else if (r_we) begin
                perf_store_cnt <= perf_store_cnt + 32'd1;
            end else begin
                perf_load_cnt <= perf_load_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_lsu_mem_port.sv
// ============================================================================
// Module      : tb_lsu_mem_port
// Description : Self-checking bench for lsu_mem_port. Directed cases plus
//               randomized transactions compared against a transaction-level
//               reference model; memory data varies per cycle so the sampling
//               cycle is observable. Honours LSU_PERF_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lsu_mem_port;
    import lsu_pkg::*;

    localparam int RL = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [2:0]  req_mode = 3'b000;
    logic        req_us = 1'b0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic        data_sram_en;
    logic        data_sram_we;
    logic [2:0]  data_sram_mode;
    logic        data_sram_us;
    logic [31:0] data_sram_rdata;
`ifdef LSU_PERF_CNT_EN
    logic [31:0] perf_load_cnt, perf_store_cnt, perf_err_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int unsigned cyc = 0;
    int en_cyc = 0;
    int we_cyc = 0;
    logic [31:0] wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic [2:0]  wr_mode = '0;
    logic        mem_fixed = 1'b0;
    int m_ld = 0, m_st = 0, m_err = 0;

    lsu_mem_port #(.READ_LATENCY(RL), .ADDR_W(32), .DATA_W(32)) dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_we          (req_we),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .req_mode        (req_mode),
        .req_us          (req_us),
        .resp_valid      (resp_valid),
        .resp_ready      (resp_ready),
        .resp_rdata      (resp_rdata),
        .resp_err        (resp_err),
`ifdef LSU_PERF_CNT_EN
        .perf_load_cnt   (perf_load_cnt),
        .perf_store_cnt  (perf_store_cnt),
        .perf_err_cnt    (perf_err_cnt),
`endif
        .data_sram_addr  (data_sram_addr),
        .data_sram_wdata (data_sram_wdata),
        .data_sram_en    (data_sram_en),
        .data_sram_we    (data_sram_we),
        .data_sram_mode  (data_sram_mode),
        .data_sram_us    (data_sram_us),
        .data_sram_rdata (data_sram_rdata)
    );

    always #5 clk = ~clk;

    // Memory content depends on address and on the current cycle
    function automatic logic [31:0] mem_fn(input logic [31:0] a, input int unsigned c);
        if (mem_fixed) return 32'hDEADBEEF;
        return (a * 32'h01000193) ^ (c * 32'h9E3779B1) ^ 32'h5A5A0000;
    endfunction

    assign data_sram_rdata = mem_fn(data_sram_addr, cyc);

    // Cycle counter and SRAM activity monitor
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (data_sram_en) en_cyc <= en_cyc + 1;
        if (data_sram_en && data_sram_we) begin
            we_cyc  <= we_cyc + 1;
            wr_addr <= data_sram_addr;
            wr_data <= data_sram_wdata;
            wr_mode <= data_sram_mode;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_perf();
`ifdef LSU_PERF_CNT_EN
        check("perf_load", perf_load_cnt, m_ld);
        check("perf_store", perf_store_cnt, m_st);
        check("perf_err", perf_err_cnt, m_err);
`endif
    endtask

    task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [2:0] mode, input logic us, input int hold);
        int unsigned c;
        int k, e0, w0, size, lat_exp;
        logic exp_err;
        logic [31:0] exp_rd;
        size = (mode == 3'b001) ? 1 : (mode == 3'b010) ? 2 : (mode == 3'b100) ? 4 : 0;
        exp_err = (size == 0) ? 1'b1 : ((addr % size) != 0);
        e0 = en_cyc;
        w0 = we_cyc;
        req_valid = 1'b1; req_we = we; req_addr = addr;
        req_wdata = wdata; req_mode = mode; req_us = us;
        k = 0;
        while (!req_ready && k < 20) begin @(posedge clk); #1; k++; end
        if (!req_ready) begin
            check("accept_timeout", 0, 1);
            req_valid = 1'b0;
            return;
        end
        c = cyc;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_we = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
        req_mode = 3'($urandom); req_us = 1'($urandom);
        k = 0;
        while (!resp_valid && k < 20) begin @(posedge clk); #1; k++; end
        if (!resp_valid) begin
            check("resp_timeout", 0, 1);
            return;
        end
        lat_exp = (exp_err || we) ? 2 : RL + 2;
        exp_rd  = (exp_err || we) ? 32'h0 : mem_fn(addr, c + 1 + RL);
        check("latency", cyc - c, lat_exp);
        check("rdata", resp_rdata, exp_rd);
        check("err", resp_err, exp_err);
        check("en_cycles", en_cyc - e0, exp_err ? 0 : (we ? 1 : RL + 1));
        check("we_cycles", we_cyc - w0, (we && !exp_err) ? 1 : 0);
        if (!exp_err) begin
            check("sram_us", data_sram_us, us);
            if (we) begin
                check("wr_addr", wr_addr, addr);
                check("wr_data", wr_data, wdata);
                check("wr_mode", wr_mode, mode);
            end
        end
        if (exp_err) m_err++;
        else if (we) m_st++;
        else m_ld++;
        check_perf();
        for (int i = 0; i < hold; i++) begin
            req_valid = 1'b1;
            @(posedge clk); #1;
            check("hold_valid", resp_valid, 1);
            check("hold_rdata", resp_rdata, exp_rd);
            check("hold_err", resp_err, exp_err);
            check("hold_ready", req_ready, 0);
        end
        req_valid = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        check("resp_clear", resp_valid, 0);
        check("ready_back", req_ready, 1);
        check("en_idle", data_sram_en, 0);
    endtask

    initial begin
        logic [2:0] md;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", req_ready, 1);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_resp_err", resp_err, 0);
        check("rst_resp_rdata", resp_rdata, 0);
        check("rst_sram", {data_sram_addr, data_sram_wdata[30:0], data_sram_en,
                           data_sram_we, data_sram_mode, data_sram_us}, 64'h0);
        check("rst_sram_wd_msb", data_sram_wdata[31], 0);
        check_perf();
        rst = 1'b0;

        mem_fixed = 1'b1;
        run_txn(1'b0, 32'h100, 32'h0, MODE_W, 1'b0, 0);
        mem_fixed = 1'b0;
        run_txn(1'b1, 32'h103, 32'h000000AB, MODE_B, 1'b0, 0);
        run_txn(1'b0, 32'h101, 32'h0, MODE_H, 1'b1, 0);
        run_txn(1'b0, 32'h104, 32'h0, 3'b011, 1'b0, 0);
        run_txn(1'b0, 32'h200, 32'h0, MODE_W, 1'b1, 5);
        run_txn(1'b1, 32'h204, 32'h12345678, MODE_W, 1'b0, 5);

        // Reset while the load is in WAIT
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h40; req_mode = MODE_W;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        check("wait_en", data_sram_en, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        m_ld = 0; m_st = 0; m_err = 0;
        check("abort_resp_valid", resp_valid, 0);
        check("abort_en", data_sram_en, 0);
        check("abort_ready", req_ready, 1);
        check_perf();

        for (int t = 0; t < 60; t++) begin
            case ($urandom_range(0, 4))
                0: md = MODE_B;
                1: md = MODE_H;
                2, 3: md = MODE_W;
                default: md = 3'($urandom);
            endcase
            run_txn(1'($urandom), 32'h300 + 32'($urandom_range(0, 63)), $urandom,
                    md, 1'($urandom), $urandom_range(0, 3));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/lsu_mem_port.md
Name: lsu_mem_port

Overview:
- Load/store initiator sitting in the MEM stage between the pipeline and data_ram.
- Accepts one load or store request per transaction over a valid/ready handshake.
- Drives the data_sram_* interface, holding address/mode stable for the programmed read latency, then captures the read data.
- Detects misaligned accesses without touching memory; returns a buffered response via valid/ready.

Parameters:
- READ_LATENCY, 1, cycles after the request cycle before data_sram_rdata is sampled (legal range 0..7; 0 = sampled in the request cycle).
- ADDR_W, 32, address width.
- DATA_W, 32, data width.

Ports:
- clk  input  1  system clock
- rst  input  1  reset, synchronous, active-high
- req_valid  input  1  request present
- req_ready  output  1  block can accept a request
- req_we  input  1  1 = store, 0 = load
- req_addr  input  ADDR_W  byte address
- req_wdata  input  DATA_W  store data, right-aligned
- req_mode  input  3  access size, one-hot: 001 = byte, 010 = half, 100 = word
- req_us  input  1  load is zero-extended when 1
- resp_valid  output  1  response held
- resp_ready  input  1  consumer accepts response
- resp_rdata  output  DATA_W  load data, already extended by the memory; 0 for stores and errors
- resp_err  output  1  misaligned or illegal mode
- data_sram_addr  output  ADDR_W  memory address
- data_sram_wdata  output  DATA_W  memory write data
- data_sram_en  output  1  memory enable
- data_sram_we  output  1  memory write strobe
- data_sram_mode  output  3  size to memory
- data_sram_us  output  1  sign/zero select to memory
- data_sram_rdata  input  DATA_W  memory read data (combinational)

Behaviour:
- Reset values:
  - state = IDLE
  - req_ready = 1
  - resp_valid = 0, resp_err = 0
  - resp_rdata = 0
  - all data_sram_* outputs = 0
  - latency counter = 0
- Request capture:
  - A request is accepted on a cycle with req_valid && req_ready.
  - Fields are registered and data_sram_addr/wdata/mode/us drive from those registers until the transaction leaves ACCESS/WAIT.
- Error check at accept. The request is an error if any of the following holds:
  - mode is not one-hot;
  - half access with addr[0] = 1;
  - word access with addr[1:0] != 0.
- FSM:
  - IDLE: req_ready = 1. On accept, go to ERR if the request is an error, else to ACCESS.
  - ACCESS (one cycle): data_sram_en = 1; data_sram_we = 1 for stores in this cycle only, so exactly one write strobe per store.
    - Store: go to RESP with rdata = 0.
    - Load with READ_LATENCY = 0: capture data_sram_rdata and go to RESP.
    - Load with READ_LATENCY > 0: load counter with READ_LATENCY and go to WAIT.
  - WAIT (loads only): data_sram_en held 1, we = 0. Counter decrements each cycle; on the cycle the counter equals 1, capture rdata and go to RESP.
  - ERR: go to RESP with resp_err = 1, rdata = 0. data_sram_en is never asserted.
  - RESP: resp_valid = 1 with outputs stable. On resp_ready, go to IDLE. req_ready stays 0 in every state except IDLE.
- Load latency: accept to resp_valid = READ_LATENCY + 2 cycles.
- Store latency: 2 cycles. Error latency: 2 cycles.
- No back-to-back overlap: at most one outstanding transaction.
- req_valid deasserted while req_ready = 0: no effect.
- Reset mid-operation: abort immediately. Pending response is dropped; a store aborted before ACCESS never writes.
- Outside ACCESS/WAIT, data_sram_en = 0 and data_sram_we = 0. Address/data outputs retain their last value.

Optional Feature:
- LSU_PERF_CNT_EN defined:
  - Adds 32-bit outputs perf_load_cnt, perf_store_cnt and perf_err_cnt, reset to 0.
  - Each increments by 1 when a load, store or error transaction enters RESP.
  - Counters wrap modulo 2^32.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package lsu_pkg holds:
  - MODE_B, MODE_H, MODE_W encodings;
  - FSM state typedef (IDLE, ACCESS, WAIT, ERR, RESP);
  - the misalignment-check function.
- One natural sub-module: lsu_resp_buf, the response holding register with valid/ready.

Test Plan:
- Load word, addr 0x100, mem word 0xDEADBEEF, READ_LATENCY 1 -> en high for 2 cycles, we = 0; resp_valid on cycle 3 with rdata 0xDEADBEEF, err 0.
- Store byte, addr 0x103, wdata 0x000000AB -> exactly one cycle with en = we = 1, addr 0x103, mode 001; resp_valid next cycle, err 0, rdata 0.
- Load half, addr 0x101 -> resp_err = 1, rdata 0, data_sram_en never asserted.
- Illegal mode 011 -> resp_err = 1, no memory access.
- resp_ready held 0 for 5 cycles, then new req_valid -> req_ready stays 0, resp fields stable; accepted only after the handshake completes.
- rst asserted during WAIT -> next cycle state IDLE, resp_valid 0, en 0.
- With LSU_PERF_CNT_EN: 3 loads, 2 stores, 1 misaligned -> counters read 3, 2, 1.
